// File: rtl/pixel_buffer_pkg.sv
// Shared types and constants for the pixel buffer: FSM state encoding and
// the default image size (28x28 = 784 pixels).
package pixel_buffer_pkg;

  localparam int NUM_PIXELS_DEFAULT = 784;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } pb_state_e;

endpackage

// File: rtl/pixel_buffer_if.sv
// Load/read bus of the pixel buffer. The master side (image source and
// multiplier) drives frame/pixel/address signals; the slave side (the buffer)
// returns handshake, status and read data.
interface pixel_buffer_if #(
  parameter int ADDR_BITS  = 10,
  parameter int PIXEL_BITS = 8
);

  logic                  frame_start;
  logic [PIXEL_BITS-1:0] pixel_in;
  logic                  pixel_valid;
  logic                  pixel_ready;
  logic [ADDR_BITS-1:0]  pixel_address_1;
  logic [ADDR_BITS-1:0]  pixel_address_2;
  logic [PIXEL_BITS-1:0] pixel_value_1;
  logic [PIXEL_BITS-1:0] pixel_value_2;
  logic                  image_ready;
  logic [ADDR_BITS-1:0]  load_count;

  modport master (
    output frame_start, pixel_in, pixel_valid, pixel_address_1, pixel_address_2,
    input  pixel_ready, pixel_value_1, pixel_value_2, image_ready, load_count
  );

  modport slave (
    input  frame_start, pixel_in, pixel_valid, pixel_address_1, pixel_address_2,
    output pixel_ready, pixel_value_1, pixel_value_2, image_ready, load_count
  );

endinterface

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear and enable that saturates at MAX_COUNT.
// Used as the write-address / load counter of the pixel buffer.
module flex_counter #(
  parameter int                 WIDTH     = 10,
  parameter logic [WIDTH-1:0]   MAX_COUNT = '1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear_i,
  input  logic             count_enable_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear wins over enable; never step past MAX_COUNT.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_enable_i && (count_q != MAX_COUNT)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pixel_buffer.sv
// Pixel buffer: loads one image of NUM_PIXELS pixels in raster order and
// serves two independent registered read ports to the multiplier.
// Optional feature: define PIXEL_BUFFER_CHECKSUM_EN to add a 16-bit
// running sum of accepted pixels on output port checksum.
module pixel_buffer
  import pixel_buffer_pkg::*;
#(
  parameter int NUM_PIXELS = NUM_PIXELS_DEFAULT,
  parameter int ADDR_BITS  = 10,
  parameter int PIXEL_BITS = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  pixel_buffer_if.slave    bus
`ifdef PIXEL_BUFFER_CHECKSUM_EN
  ,
  output logic [15:0]      checksum
`endif
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR  = ADDR_BITS'(NUM_PIXELS - 1);
  localparam logic [ADDR_BITS-1:0] FULL_COUNT = ADDR_BITS'(NUM_PIXELS);

  pb_state_e             state_q;
  logic                  image_ready_q;
  logic                  accept;
  logic [ADDR_BITS-1:0]  wr_addr;
  logic [PIXEL_BITS-1:0] mem_q [NUM_PIXELS];
  logic [PIXEL_BITS-1:0] value_1_q, value_1_d;
  logic [PIXEL_BITS-1:0] value_2_q, value_2_d;

  // frame_start blocks acceptance in the same cycle so the pixel is dropped.
  assign bus.pixel_ready = (state_q == LOAD) && !bus.frame_start;
  assign accept          = bus.pixel_valid && bus.pixel_ready;

  // Write address doubles as the visible load count; it saturates at a full image.
  flex_counter #(
    .WIDTH     (ADDR_BITS),
    .MAX_COUNT (FULL_COUNT)
  ) u_wr_counter (
    .clk            (clk),
    .n_rst          (n_rst),
    .clear_i        (bus.frame_start),
    .count_enable_i (accept),
    .count_o        (wr_addr)
  );

  // Load-control FSM with registered image_ready.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      image_ready_q <= 1'b0;
    end else if (bus.frame_start) begin
      state_q       <= LOAD;
      image_ready_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (accept && (wr_addr == LAST_ADDR)) begin
            state_q       <= READY;
            image_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q       <= state_q;
          image_ready_q <= image_ready_q;
        end
      endcase
    end
  end

  // Storage write port; contents survive reset and frame_start.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_addr] <= bus.pixel_in;
    end
  end

  // Read data select: out-of-range addresses return zero.
  always_comb begin
    value_1_d = '0;
    value_2_d = '0;
    if (bus.pixel_address_1 <= LAST_ADDR) begin
      value_1_d = mem_q[bus.pixel_address_1];
    end
    if (bus.pixel_address_2 <= LAST_ADDR) begin
      value_2_d = mem_q[bus.pixel_address_2];
    end
  end

  // Registered read ports; a same-cycle write is not forwarded (old data wins).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      value_1_q <= '0;
      value_2_q <= '0;
    end else begin
      value_1_q <= value_1_d;
      value_2_q <= value_2_d;
    end
  end

  assign bus.pixel_value_1 = value_1_q;
  assign bus.pixel_value_2 = value_2_q;
  assign bus.image_ready   = image_ready_q;
  assign bus.load_count    = wr_addr;

`ifdef PIXEL_BUFFER_CHECKSUM_EN
  logic [15:0] checksum_q;

  // Running modulo-2^16 sum of accepted pixels, restarted with each frame.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      checksum_q <= '0;
    end else if (bus.frame_start) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= checksum_q + 16'(bus.pixel_in);
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_pixel_buffer.sv
// Self-checking bench for pixel_buffer: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// behavioural image-buffer model.
module tb_pixel_buffer;

  localparam int NP = 784;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;

  always #5 clk = ~clk;

  pixel_buffer_if #(.ADDR_BITS(10), .PIXEL_BITS(8)) bus();

`ifdef PIXEL_BUFFER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  pixel_buffer #(
    .NUM_PIXELS (NP),
    .ADDR_BITS  (10),
    .PIXEL_BITS (8)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
`ifdef PIXEL_BUFFER_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [7:0] m_mem   [NP];
  bit         m_known [NP];
  bit         m_loading = 0;
  bit         m_ready   = 0;
  int         m_count   = 0;
  int         m_v1 = 0, m_v2 = 0;
  bit         m_v1_ok = 1, m_v2_ok = 1;
  int         m_cks = 0;
  int         ma1, ma2;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_loading = 0;
      m_ready   = 0;
      m_count   = 0;
      m_v1      = 0;
      m_v2      = 0;
      m_v1_ok   = 1;
      m_v2_ok   = 1;
      m_cks     = 0;
    end else begin
      ma1 = int'(bus.pixel_address_1);
      ma2 = int'(bus.pixel_address_2);
      if (ma1 >= NP) begin m_v1 = 0; m_v1_ok = 1; end
      else begin m_v1 = int'(m_mem[ma1]); m_v1_ok = m_known[ma1]; end
      if (ma2 >= NP) begin m_v2 = 0; m_v2_ok = 1; end
      else begin m_v2 = int'(m_mem[ma2]); m_v2_ok = m_known[ma2]; end
      if (bus.frame_start) begin
        m_loading = 1;
        m_ready   = 0;
        m_count   = 0;
        m_cks     = 0;
      end else if (m_loading && bus.pixel_valid) begin
        m_mem[m_count]   = bus.pixel_in;
        m_known[m_count] = 1;
        m_cks            = (m_cks + int'(bus.pixel_in)) % 65536;
        m_count++;
        if (m_count == NP) begin
          m_loading = 0;
          m_ready   = 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("pixel_ready", int'(bus.pixel_ready), int'(m_loading && !bus.frame_start));
    chk("image_ready", int'(bus.image_ready), int'(m_ready));
    chk("load_count",  int'(bus.load_count),  m_count);
    if (m_v1_ok) chk("pixel_value_1", int'(bus.pixel_value_1), m_v1);
    if (m_v2_ok) chk("pixel_value_2", int'(bus.pixel_value_2), m_v2);
`ifdef PIXEL_BUFFER_CHECKSUM_EN
    chk("checksum", int'(checksum), m_cks);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  initial begin
    bus.frame_start     = 1'b0;
    bus.pixel_in        = '0;
    bus.pixel_valid     = 1'b0;
    bus.pixel_address_1 = '0;
    bus.pixel_address_2 = '0;

    // Reset state
    repeat (3) tick();
    chk("rst image_ready", int'(bus.image_ready),   0);
    chk("rst load_count",  int'(bus.load_count),    0);
    chk("rst pixel_ready", int'(bus.pixel_ready),   0);
    chk("rst value_1",     int'(bus.pixel_value_1), 0);
    chk("rst value_2",     int'(bus.pixel_value_2), 0);
    n_rst = 1'b1;
    tick();

    // Full load of i mod 256
    start_frame();
    bus.pixel_valid = 1'b1;
    for (int i = 0; i < NP; i++) begin
      bus.pixel_in = 8'(i % 256);
      tick();
      if (i == NP - 2) chk("image_ready before last", int'(bus.image_ready), 0);
    end
    bus.pixel_valid = 1'b0;
    chk("image_ready after load", int'(bus.image_ready), 1);
    chk("load_count after load",  int'(bus.load_count),  784);

    // Dual reads, corner addresses and same address
    bus.pixel_address_1 = 10'd0;
    bus.pixel_address_2 = 10'd783;
    tick();
    chk("read addr 0",   int'(bus.pixel_value_1), 8'h00);
    chk("read addr 783", int'(bus.pixel_value_2), 8'h0F);
    bus.pixel_address_1 = 10'd5;
    bus.pixel_address_2 = 10'd5;
    tick();
    chk("same addr port1", int'(bus.pixel_value_1), 8'h05);
    chk("same addr port2", int'(bus.pixel_value_2), 8'h05);

    // Valid while READY is ignored
    bus.pixel_valid     = 1'b1;
    bus.pixel_in        = 8'hAA;
    bus.pixel_address_1 = 10'd10;
    #1;
    chk("pixel_ready in READY", int'(bus.pixel_ready), 0);
    tick();
    tick();
    bus.pixel_valid = 1'b0;
    chk("addr 10 unchanged",   int'(bus.pixel_value_1), 8'h0A);
    chk("load_count held 784", int'(bus.load_count),    784);

    // Out-of-range read
    bus.pixel_address_1 = 10'd900;
    tick();
    chk("read addr 900", int'(bus.pixel_value_1), 0);

    // frame_start coincident with valid drops the pixel
    start_frame();
    bus.pixel_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.pixel_in = 8'($urandom);
      tick();
    end
    chk("load_count 100", int'(bus.load_count), 100);
    bus.frame_start = 1'b1;
    bus.pixel_in    = 8'h5C;
    #1;
    chk("pixel_ready with frame_start", int'(bus.pixel_ready), 0);
    tick();
    bus.frame_start = 1'b0;
    chk("load_count cleared", int'(bus.load_count), 0);
    bus.pixel_in = 8'h3E;
    tick();
    bus.pixel_valid     = 1'b0;
    bus.pixel_address_1 = 10'd0;
    chk("load_count after restart", int'(bus.load_count), 1);
    tick();
    chk("first pixel at addr 0", int'(bus.pixel_value_1), 8'h3E);

    // Reset mid-load
    start_frame();
    bus.pixel_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      bus.pixel_in = 8'($urandom);
      tick();
    end
    chk("load_count 50", int'(bus.load_count), 50);
    n_rst = 1'b0;
    #1;
    chk("mid reset load_count",  int'(bus.load_count),    0);
    chk("mid reset image_ready", int'(bus.image_ready),   0);
    chk("mid reset pixel_ready", int'(bus.pixel_ready),   0);
    chk("mid reset value_1",     int'(bus.pixel_value_1), 0);
    tick();
    tick();
    n_rst = 1'b1;
    repeat (3) tick();
    chk("idle after reset ignores valid", int'(bus.load_count), 0);
    bus.pixel_valid = 1'b0;

    // Randomized phase
    start_frame();
    for (int c = 0; c < 4000; c++) begin
      int r;
      bus.frame_start = ($urandom_range(0, 1999) == 0) || (c == 2000);
      bus.pixel_valid = ($urandom_range(0, 3) != 0);
      bus.pixel_in    = 8'($urandom);
      r = int'($urandom_range(0, 7));
      if (r == 0)      bus.pixel_address_1 = bus.load_count;
      else if (r == 1) bus.pixel_address_1 = 10'($urandom_range(0, 1023));
      else             bus.pixel_address_1 = 10'($urandom_range(0, NP - 1));
      if ($urandom_range(0, 3) == 0) bus.pixel_address_2 = bus.pixel_address_1;
      else                           bus.pixel_address_2 = 10'($urandom_range(0, 1023));
      tick();
    end
    bus.frame_start = 1'b0;
    bus.pixel_valid = 1'b0;
    tick();

`ifdef PIXEL_BUFFER_CHECKSUM_EN
    // 784 x 0xFF = 199920, mod 65536 = 3312 = 0x0CF0
    start_frame();
    bus.pixel_valid = 1'b1;
    bus.pixel_in    = 8'hFF;
    repeat (NP) tick();
    bus.pixel_valid = 1'b0;
    chk("checksum all 0xFF", int'(checksum), 16'h0CF0);
    chk("checksum image_ready", int'(bus.image_ready), 1);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
